// File: rtl/fsqrt_pkg.sv
// Shared definitions for the sequential Newton-Raphson square-root controller.
//   state_e   : controller states
//   DP_W      : datapath width of the iteration stage
//   BIAS      : IEEE-754 single exponent bias
//   QNAN      : canonical quiet NaN
//   POS_INF   : positive infinity
//   seed_calc : elaboration-time helper that builds one seed ROM entry
package fsqrt_pkg;

  localparam int unsigned DP_W = 64;
  localparam int unsigned BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StIter,
    StRound,
    StDone
  } state_e;

  // idx = {E[0], M[22:16]}. Returns the 7 fraction bits of sqrt(radicand), rounded to nearest.
  // sqrt(r) * 128 = sqrt(r * 16384), so the radicand is scaled to an integer v and an
  // integer square root is taken; round-to-nearest adds one when v > s*s + s.
  function automatic logic [6:0] seed_calc(input int unsigned idx);
    int unsigned v;
    int unsigned s;
    v = (128 + (idx % 128)) * ((idx >= 128) ? 32'd128 : 32'd256);
    s = 0;
    for (int unsigned k = 1; k <= 256; k++) begin
      if (k * k <= v) s = k;
    end
    if (v > s * s + s) s = s + 1;
    if (s > 255) s = 255;
    return 7'(s - 128);
  endfunction

endpackage

// File: rtl/fsqrt_seed_rom.sv
// Seed ROM for the square-root iteration.
//   idx  : {E[0], M[22:16]} of the operand (E[0] = 1 means radicand 1.M, else 2*1.M)
//   seed : 7 fraction bits of the initial estimate; the integer bit is implied 1
module fsqrt_seed_rom
  import fsqrt_pkg::*;
(
  input  logic [7:0] idx,
  output logic [6:0] seed
);

  logic [6:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam logic [6:0] SeedVal = seed_calc(i);
    assign rom[i] = SeedVal;
  end

  assign seed = rom[idx];

endmodule

// File: rtl/fsqrt_seq.sv
// Multi-cycle IEEE-754 single square root, one Newton-Raphson step per clock through a
// single divide/add/halve stage, with round-to-nearest-even and special-case handling.
// Optional feature: define FSQRT_SEQ_EARLY_EXIT_EN to stop iterating once x stops changing.
//   clk, rstn              : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      : operand handshake; in_ready only while idle
//   in_data                : IEEE-754 single operand
//   out_valid/out_ready    : result handshake; outputs held until accepted
//   out_data, out_invalid  : result and invalid-operation flag
//   iters_used             : Newton iterations executed for this result (0 for specials)
//   busy                   : an operation is in flight
module fsqrt_seq
  import fsqrt_pkg::*;
#(
  parameter int unsigned N_ITER = 2,
  parameter int unsigned ITER_W = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_invalid,
  output logic [ITER_W-1:0] iters_used,
  output logic              busy
);

  state_e            state_q;
  logic [30:0]       op_q;     // exponent and mantissa of the accepted operand
  logic [DP_W-1:0]   x_q;
  logic [ITER_W-1:0] cnt_q;

  // Special-operand decode straight from the input bus.
  logic        is_special;
  logic        spec_invalid;
  logic [31:0] spec_data;

  always_comb begin
    is_special   = 1'b1;
    spec_invalid = 1'b0;
    spec_data    = '0;
    if (in_data[30:23] == 8'h00) begin
      spec_data = {in_data[31], 31'b0};  // zero, or denormal flushed to signed zero
    end else if (in_data[30:23] == 8'hFF && in_data[22:0] != '0) begin
      spec_data = QNAN;
    end else if (in_data[31]) begin
      spec_data    = QNAN;
      spec_invalid = 1'b1;
    end else if (in_data[30:23] == 8'hFF) begin
      spec_data = POS_INF;
    end else begin
      is_special = 1'b0;
    end
  end

  // Radicand in Q.31: 1.M for odd biased exponents, 2*1.M for even ones.
  logic [DP_W-1:0] rad;
  assign rad = op_q[23] ? {32'b0, 1'b1, op_q[22:0], 8'b0} : {31'b0, 1'b1, op_q[22:0], 9'b0};

  logic [6:0] seed7;

  fsqrt_seed_rom u_seed_rom (
    .idx  ({op_q[23], op_q[22:16]}),
    .seed (seed7)
  );

  // In SEED the ROM estimate feeds the stage directly, so the first iteration overlaps
  // the seed load. R and x both carry 31 fraction bits; pre-shifting the dividend by 31
  // keeps the quotient in that format. x never drops below 1.0, so no divide-by-zero.
  logic [DP_W-1:0]   x_cur;
  logic [DP_W-1:0]   quot;
  logic [DP_W-1:0]   x_nxt;
  logic [ITER_W-1:0] cnt_nxt;
  logic              conv;
  logic              iter_done;

  assign x_cur     = (state_q == StSeed) ? {32'b0, 1'b1, seed7, 24'b0} : x_q;
  assign quot      = (rad << 31) / x_cur;
  assign x_nxt     = (x_cur + quot) >> 1;
  assign cnt_nxt   = cnt_q + 1'b1;

`ifdef FSQRT_SEQ_EARLY_EXIT_EN
  assign conv = (x_nxt == x_cur);
`else
  assign conv = 1'b0;
`endif

  assign iter_done = (cnt_nxt == ITER_W'(N_ITER)) || conv;

  // Round-to-nearest-even on x (Q1.31, integer bit always set here).
  logic [8:0]  exp_sum;
  logic [7:0]  res_exp;
  logic        rnd_inc;
  logic [23:0] mant_sum;
  logic [31:0] round_data;

  always_comb begin
    exp_sum    = {1'b0, op_q[30:23]} + 9'(BIAS);
    res_exp    = 8'(exp_sum >> 1);
    rnd_inc    = x_q[7] & (x_q[6] | (|x_q[5:0]) | x_q[8]);
    mant_sum   = {1'b0, x_q[30:8]} + 24'(rnd_inc);
    // A carry out of the mantissa leaves mant_sum[22:0] zero and bumps the exponent.
    round_data = {1'b0, res_exp + 8'(mant_sum[23]), mant_sum[22:0]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      op_q        <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_invalid <= 1'b0;
      iters_used  <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q     <= in_data[30:0];
            cnt_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (is_special) begin
              out_data    <= spec_data;
              out_invalid <= spec_invalid;
              iters_used  <= '0;
              out_valid   <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StSeed;
            end
          end
        end
        StSeed, StIter: begin
          x_q     <= x_nxt;
          cnt_q   <= cnt_nxt;
          state_q <= iter_done ? StRound : StIter;
        end
        StRound: begin
          out_data    <= round_data;
          out_invalid <= 1'b0;
          iters_used  <= cnt_q;
          out_valid   <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsqrt_seq.sv
// Self-checking bench for fsqrt_seq: directed vector table, back-pressure and mid-operation
// reset sequences, then random operands against a plain-arithmetic reference model.
module tb_fsqrt_seq;

`ifdef FSQRT_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int NIT  = 2;
  localparam int EIT  = EE ? 1 : 2;  // iterations for operands whose seed is already exact
  localparam int ELAT = EIT + 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic [2:0]  iters_used;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fsqrt_seq #(
    .N_ITER (NIT),
    .ITER_W (3)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_invalid (out_invalid),
    .iters_used  (iters_used),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " out_data"}, 64'(out_data), 64'd0);
    check({tag, " out_invalid"}, 64'(out_invalid), 64'd0);
    check({tag, " iters_used"}, 64'(iters_used), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  // Issue one operand, wait for the result, complete the handshake.
  // lat counts clock edges from the accepting edge (as 1) to the edge that raised out_valid.
  task automatic run_op(input logic [31:0] a, output logic [31:0] d, output logic inv,
                        output int it, output int lat);
    check("ready before issue", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d   = out_data;
    inv = out_invalid;
    it  = int'(iters_used);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reference: IEEE rules for specials, Newton iteration on exact integers otherwise.
  task automatic model(input logic [31:0] a, output logic [31:0] d, output logic inv,
                       output int it, output int lat);
    logic [7:0]      e;
    logic [22:0]     m;
    real             r;
    int              s7;
    longint unsigned rr;
    longint unsigned x;
    longint unsigned xn;
    longint unsigned sig;
    longint unsigned rem;
    int              ex;
    e   = a[30:23];
    m   = a[22:0];
    inv = 1'b0;
    it  = 0;
    lat = 1;
    if (e == 8'd0) begin
      d = {a[31], 31'b0};
    end else if (e == 8'hFF && m != 23'd0) begin
      d = 32'h7FC0_0000;
    end else if (a[31]) begin
      d   = 32'h7FC0_0000;
      inv = 1'b1;
    end else if (e == 8'hFF) begin
      d = 32'h7F80_0000;
    end else begin
      r  = (1.0 + real'(m >> 16) / 128.0) * (e[0] ? 1.0 : 2.0);
      s7 = $rtoi($sqrt(r) * 128.0 + 0.5) - 128;
      if (s7 > 127) s7 = 127;
      rr = (64'd1 << 31) | (64'(m) << 8);
      if (!e[0]) rr = rr << 1;
      x = longint'(128 + s7) << 24;
      for (int i = 0; i < NIT; i++) begin
        xn = (x + (rr << 31) / x) >> 1;
        it++;
        if (EE && xn == x) break;
        x = xn;
      end
      x = xn;
      sig = x >> 8;
      rem = x & 64'hFF;
      if (rem > 64'h80 || (rem == 64'h80 && sig[0])) sig = sig + 1;
      ex = (int'(e) + 127) / 2;
      if (sig == (64'd1 << 24)) begin
        sig = sig >> 1;
        ex  = ex + 1;
      end
      d   = {1'b0, 8'(ex), sig[22:0]};
      lat = it + 2;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        inv;
    int          it;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] d;
    logic [31:0] md;
    logic        inv;
    logic        minv;
    int          it;
    int          mit;
    int          lat;
    int          mlat;
    int          n;
    logic [31:0] a;

    vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 1'b0, EIT, ELAT};  // 4.0
    vecs[1]  = '{32'h4000_0000, 32'h3FB5_04F3, 1'b0, 2, 4};       // 2.0
    vecs[2]  = '{32'h3E80_0000, 32'h3F00_0000, 1'b0, EIT, ELAT};  // 0.25
    vecs[3]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, EIT, ELAT};  // 1.0
    vecs[4]  = '{32'h4110_0000, 32'h4040_0000, 1'b0, EIT, ELAT};  // 9.0
    vecs[5]  = '{32'hBF80_0000, 32'h7FC0_0000, 1'b1, 0, 1};       // -1.0
    vecs[6]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 0, 1};       // +inf
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1};       // -0
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 0, 1};       // +0
    vecs[9]  = '{32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 0, 1};       // NaN
    vecs[10] = '{32'hFF80_0000, 32'h7FC0_0000, 1'b1, 0, 1};       // -inf
    vecs[11] = '{32'h0040_0000, 32'h0000_0000, 1'b0, 0, 1};       // +denormal
    vecs[12] = '{32'h8040_0000, 32'h8000_0000, 1'b0, 0, 1};       // -denormal

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rstn      = 1'b1;
    #2 rstn = 1'b0;
    #10;
    check_reset_outputs("reset");
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, d, inv, it, lat);
      check($sformatf("vec%0d data", i), 64'(d), 64'(vecs[i].d));
      check($sformatf("vec%0d invalid", i), 64'(inv), 64'(vecs[i].inv));
      check($sformatf("vec%0d iters", i), 64'(it), 64'(vecs[i].it));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Back-pressure: result held, new operand refused until the DONE handshake.
    in_valid = 1'b1;
    in_data  = 32'h4080_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp valid", 64'(out_valid), 64'd1);
    check("bp first data", 64'(out_data), 64'h4000_0000);
    in_valid = 1'b1;
    in_data  = 32'h4110_0000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d data", k), 64'(out_data), 64'h4000_0000);
      check($sformatf("bp%0d valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d busy", k), 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp release valid", 64'(out_valid), 64'd0);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("bp stall operand dropped", 64'(busy), 64'd0);

    // Reset in the middle of ITER aborts the operation.
    run_op(32'hBF80_0000, d, inv, it, lat);  // leave non-reset values on the outputs
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    #2 rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    check("midreset no result", 64'(out_valid), 64'd0);
    run_op(32'h4080_0000, d, inv, it, lat);
    check("post-reset data", 64'(d), 64'h4000_0000);
    check("post-reset latency", 64'(lat), 64'(ELAT));

    // Random operands, mostly positive normals, against the reference model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      else a = $urandom;
      model(a, md, minv, mit, mlat);
      run_op(a, d, inv, it, lat);
      check($sformatf("rnd %0h data", a), 64'(d), 64'(md));
      check($sformatf("rnd %0h invalid", a), 64'(inv), 64'(minv));
      check($sformatf("rnd %0h iters", a), 64'(it), 64'(mit));
      check($sformatf("rnd %0h latency", a), 64'(lat), 64'(mlat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
